// File: rtl/axi_read_arbiter_pkg.sv
// Shared types for the AXI read-address arbiter.
// AR payload layout, requester tags and arbiter states.
package axi_pkg;

  localparam int ID_WIDTH   = 13;
  localparam int ADDR_WIDTH = 64;
  localparam int ID_TAG_BIT = 0;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ar_req_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AR channel plus R handshake/routing signals for one AXI read port.
// The requester drives master; the arbiter's cache side uses slave.
interface axi_read_arbiter_if;
  import axi_pkg::*;

  logic                arvalid;
  logic                arready;
  ar_req_t             ar;
  logic [ID_WIDTH-1:0] rid;
  logic                rvalid;
  logic                rlast;
  logic                rready;

  modport master (
    output arvalid, ar, rready,
    input  arready, rid, rvalid, rlast
  );

  modport slave (
    input  arvalid, ar, rready,
    output arready, rid, rvalid, rlast
  );

endinterface

// File: rtl/axi_read_arbiter_counter.sv
// In-flight burst counter for one requester.
// Simultaneous inc/dec cancel; dec at zero flags underflow.
module outstanding_counter #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          underflow
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    unique case (1'b1)
      inc & ~dec: cnt_d = cnt_q + CW'(1);
      dec & ~inc: begin
        if (cnt_q == '0) underflow = 1'b1;
        else             cnt_d     = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign full  = (cnt_q == CW'(MAX));

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin sharing of one AXI AR channel between icache and dcache,
// with a held AR payload and R routing by ID tag bit.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  axi_read_arbiter_if.slave  ic,
  axi_read_arbiter_if.slave  dc,
  axi_read_arbiter_if.master m,
  output logic [CNT_W-1:0]   ic_outstanding,
  output logic [CNT_W-1:0]   dc_outstanding,
  output logic               err_unexp_r
);

  arb_state_e state_q, state_d;
  ar_req_t    ar_q, ar_d;
  req_e       last_q, last_d;
  logic       err_q, err_d;

  logic ic_full, dc_full;
  logic ic_uf, dc_uf;
  logic ic_elig, dc_elig;
  logic pick_dc, grant, accept;
  logic ic_inc, dc_inc;
  logic ic_dec, dc_dec;
  logic r_dc, r_fire;

  always_comb begin
    ic_elig = ic.arvalid & ~ic_full;
    dc_elig = dc.arvalid & ~dc_full;
    // dcache wins only if alone or if icache had the last grant
    pick_dc = dc_elig & (~ic_elig | (last_q == REQ_ICACHE));
    grant   = (state_q == IDLE) & (ic_elig | dc_elig);
    accept  = (state_q == HOLD) & m.arready;

    state_d = state_q;
    ar_d    = ar_q;
    last_d  = last_q;
    unique case (1'b1)
      grant: begin
        state_d = HOLD;
        last_d  = req_e'(pick_dc);
        ar_d    = pick_dc ? dc.ar : ic.ar;
        ar_d.id[ID_TAG_BIT] = pick_dc;
      end
      accept:  state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ar_q    <= '0;
      last_q  <= REQ_DCACHE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign ic.arready = grant & ~pick_dc;
  assign dc.arready = grant & pick_dc;
  assign m.arvalid  = (state_q == HOLD);
  assign m.ar       = ar_q;

  assign r_dc       = m.rid[ID_TAG_BIT];
  assign m.rready   = r_dc ? dc.rready : ic.rready;
  assign ic.rvalid  = m.rvalid & ~r_dc;
  assign dc.rvalid  = m.rvalid & r_dc;
  assign ic.rid     = m.rid;
  assign dc.rid     = m.rid;
  assign ic.rlast   = m.rlast;
  assign dc.rlast   = m.rlast;

  assign r_fire = m.rvalid & m.rready & m.rlast;
  assign ic_dec = r_fire & ~r_dc;
  assign dc_dec = r_fire & r_dc;
  assign ic_inc = accept & (last_q == REQ_ICACHE);
  assign dc_inc = accept & (last_q == REQ_DCACHE);

  assign err_d       = err_q | ic_uf | dc_uf;
  assign err_unexp_r = err_q;

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_ic_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (ic_inc),
    .dec       (ic_dec),
    .count     (ic_outstanding),
    .full      (ic_full),
    .underflow (ic_uf)
  );

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_dc_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (dc_inc),
    .dec       (dc_dec),
    .count     (dc_outstanding),
    .full      (dc_full),
    .underflow (dc_uf)
  );

endmodule
